spi_flash_reader: RTL

Parameterised SPI NOR flash read engine (SPI mode 0, single I/O) producing a stream of data words from a single request. It generalises the single-word 0x03 reader: configurable SCK divider, 24/32-bit addressing, optional fast-read with dummy cycles, and multi-word bursts. Output is ready/valid with backpressure that pauses SCK. It sits between the instruction/data fetch logic and the board flash pins.

---
 rtl/spi_flash_pkg.sv | 33 +++
 rtl/spi_flash_bitclk.sv | 48 ++++
 rtl/spi_flash_reader.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI NOR flash read engine.
//   - read opcodes for 3- and 4-byte addressing, normal and fast read
//   - engine state enum
//   - SPI mode-0 clock levels (SCK idles low, data launched on the falling
//     edge, captured on the rising edge)
//   - read_opcode(): picks the opcode from the address width / fast-read flag
package spi_flash_pkg;

    localparam logic [7:0] OP_READ       = 8'h03;
    localparam logic [7:0] OP_FAST_READ  = 8'h0B;
    localparam logic [7:0] OP_READ4      = 8'h13;
    localparam logic [7:0] OP_FAST_READ4 = 8'h0C;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        DATA,
        STALL,
        GAP
    } state_t;

    // Mode 0: CPOL=0, so SCK rests low and the active level is high.
    localparam logic SCK_IDLE   = 1'b0;
    localparam logic SCK_ACTIVE = 1'b1;

    function automatic logic [7:0] read_opcode(input int addr_bits, input bit fast);
        if (addr_bits == 32) return fast ? OP_FAST_READ4 : OP_READ4;
        return fast ? OP_FAST_READ : OP_READ;
    endfunction

endpackage

// File: rtl/spi_flash_bitclk.sv
// SCK generator for the flash read engine.
// Ports:
//   clk, reset  system clock, synchronous active-high reset
//   en          run the clock (chip select asserted)
//   pause       hold SCK at its idle level without advancing
//   sck         SPI clock, each phase lasts CLK_DIV clk cycles
//   rise_tick   high in the clk cycle whose closing edge raises sck
//   fall_tick   high in the clk cycle whose closing edge lowers sck
module spi_flash_bitclk
    import spi_flash_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic pause,
    output logic sck,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          run;
    logic          phase_end;

    assign run       = en && !pause;
    assign phase_end = (cnt == CW'(CLK_DIV - 1));
    assign rise_tick = run && phase_end && (sck == SCK_IDLE);
    assign fall_tick = run && phase_end && (sck == SCK_ACTIVE);

    // Stopping or pausing always parks sck at idle and restarts the phase,
    // so a resumed clock gets a full low phase before its next rising edge.
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            cnt <= '0;
            sck <= SCK_IDLE;
        end else if (phase_end) begin
            cnt <= '0;
            sck <= ~sck;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/spi_flash_reader.sv
// SPI NOR flash read engine (mode 0, single I/O). One request produces
// req_len+1 words on a ready/valid stream; a full output stalls SCK.
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   req_valid/req_ready   request handshake; req_addr, req_len latched on accept
//   out_valid/out_ready   word handshake; out_data first byte in MSBs,
//                         out_last marks word req_len
//   spi_sck, spi_cs_n, spi_mosi, spi_miso   flash pins
module spi_flash_reader
    import spi_flash_pkg::*;
#(
    parameter int ADDR_BITS    = 24,
    parameter int DATA_BYTES   = 4,
    parameter int LEN_BITS     = 8,
    parameter int CLK_DIV      = 1,
    parameter int FAST_READ    = 0,
    parameter int DUMMY_CYCLES = 8,
    parameter int CS_IDLE      = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_BITS-1:0]    req_addr,
    input  logic [LEN_BITS-1:0]     req_len,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [8*DATA_BYTES-1:0] out_data,
    output logic                    out_last,
    output logic                    spi_sck,
    output logic                    spi_cs_n,
    output logic                    spi_mosi,
    input  logic                    spi_miso
);

    localparam int          WW       = 8 * DATA_BYTES;
    localparam int          TXW      = 8 + ADDR_BITS;
    localparam logic [7:0]  OPCODE   = read_opcode(ADDR_BITS, FAST_READ != 0);
    localparam logic [15:0] CMD_N    = 16'd8;
    localparam logic [15:0] ADDR_N   = 16'(ADDR_BITS);
    localparam logic [15:0] DUMMY_N  = 16'(DUMMY_CYCLES);
    localparam logic [15:0] WORD_N   = 16'(WW);
    localparam logic [15:0] GAP_LAST = 16'((CS_IDLE > 1) ? CS_IDLE - 1 : 0);

    state_t                state;
    logic [TXW-1:0]        tx;        // bits still to send after the one on mosi
    logic [WW-1:0]         rx;
    logic [WW-1:0]         word;
    logic [15:0]           bit_cnt;   // rising edges seen in the current phase
    logic [15:0]           gap_cnt;
    logic [LEN_BITS-1:0]   len;
    logic [LEN_BITS-1:0]   word_cnt;
    logic                  last_word;
    logic                  rise_tick;
    logic                  fall_tick;

    spi_flash_bitclk #(.CLK_DIV(CLK_DIV)) u_bitclk (
        .clk       (clk),
        .reset     (reset),
        .en        (!spi_cs_n),
        .pause     (state == STALL),
        .sck       (spi_sck),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    assign word      = {rx[WW-2:0], spi_miso};
    assign last_word = (word_cnt == len);

    // Bits are counted on rising edges; the falling-edge tick that ends a
    // bit's high phase both captures MISO and launches the next MOSI bit,
    // so phase changes are decided there with bit_cnt already complete.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            spi_cs_n  <= 1'b1;
            spi_mosi  <= 1'b0;
            tx        <= '0;
            rx        <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            len       <= '0;
            word_cnt  <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            if (rise_tick) bit_cnt <= bit_cnt + 16'd1;
            if (fall_tick) begin
                spi_mosi <= tx[TXW-1];
                tx       <= {tx[TXW-2:0], 1'b0};
            end

            unique case (state)
                IDLE: if (req_valid && req_ready) begin
                    spi_mosi  <= OPCODE[7];
                    tx        <= {OPCODE[6:0], req_addr, 1'b0};
                    len       <= req_len;
                    word_cnt  <= '0;
                    bit_cnt   <= '0;
                    spi_cs_n  <= 1'b0;
                    req_ready <= 1'b0;
                    state     <= CMD;
                end
                CMD: if (fall_tick && bit_cnt == CMD_N) begin
                    bit_cnt <= '0;
                    state   <= ADDR;
                end
                ADDR: if (fall_tick && bit_cnt == ADDR_N) begin
                    bit_cnt <= '0;
                    state   <= (FAST_READ != 0) ? DUMMY : DATA;
                end
                DUMMY: if (fall_tick && bit_cnt == DUMMY_N) begin
                    bit_cnt <= '0;
                    state   <= DATA;
                end
                DATA: if (fall_tick) begin
                    rx <= word;
                    if (bit_cnt == WORD_N) begin
                        bit_cnt <= '0;
                        if (!out_valid || out_ready) begin
                            out_data  <= word;
                            out_valid <= 1'b1;
                            out_last  <= last_word;
                            if (last_word) begin
                                spi_cs_n <= 1'b1;
                                gap_cnt  <= '0;
                                state    <= GAP;
                            end else begin
                                word_cnt <= word_cnt + LEN_BITS'(1);
                            end
                        end else begin
                            // Output still occupied: park with the word in rx.
                            state <= STALL;
                        end
                    end
                end
                STALL: if (out_ready) begin
                    out_data  <= rx;
                    out_valid <= 1'b1;
                    out_last  <= last_word;
                    if (last_word) begin
                        spi_cs_n <= 1'b1;
                        gap_cnt  <= '0;
                        state    <= GAP;
                    end else begin
                        word_cnt <= word_cnt + LEN_BITS'(1);
                        state    <= DATA;
                    end
                end
                GAP: begin
                    if (gap_cnt != GAP_LAST) begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end else if (!out_valid || out_ready) begin
                        // Only go idle once the final word has left too.
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
